// File: rtl/fpu_pkg.sv
// Shared single-precision FPU definitions: field widths, canonical special
// encodings, the iterative-unit state enum and an operand classifier.
package fpu_pkg;

  localparam int EXP_W     = 8;
  localparam int MAN_W     = 23;
  localparam int BIAS      = 127;

  // Root bits per operation: 24 significand bits plus one round bit.
  localparam int ROOT_BITS = 25;
  // Radicand holds the hidden bit, the mantissa and the exponent-parity alignment.
  localparam int RAD_W     = 26;
  // Partial remainder of the restoring recurrence.
  localparam int REM_W     = 28;
  localparam int CNT_W     = 5;

  localparam logic [31:0] NAN_CANON = 32'h7fc00000;
  localparam logic [31:0] POS_INF   = 32'h7f800000;

  typedef enum logic [1:0] {IDLE, ITER, ROUND, DONE} state_t;

  typedef enum logic [1:0] {FC_ZERO, FC_INF, FC_NAN, FC_NORMAL} fclass_t;

  // Classify the magnitude field; denormals are flushed and report as zero.
  function automatic fclass_t classify(input logic [EXP_W+MAN_W-1:0] mag);
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] m;
    e = mag[EXP_W+MAN_W-1:MAN_W];
    m = mag[MAN_W-1:0];
    if (e == '0) return FC_ZERO;
    if (e == '1) return (m == '0) ? FC_INF : FC_NAN;
    return FC_NORMAL;
  endfunction

endpackage

// File: rtl/fsqrt_iter_sqrt_step.sv
// sqrt_step: one combinational step of the restoring square-root recurrence.
// Ports:
//   rem       - current partial remainder
//   root      - partial root developed so far
//   pair      - next two radicand bits (zero once the radicand is exhausted)
//   rem_next  - remainder after this step
//   root_next - root with the new bit appended
//   root_bit  - the root bit produced by this step
module sqrt_step
  import fpu_pkg::*;
(
  input  logic [REM_W-1:0]     rem,
  input  logic [ROOT_BITS-1:0] root,
  input  logic [1:0]           pair,
  output logic [REM_W-1:0]     rem_next,
  output logic [ROOT_BITS-1:0] root_next,
  output logic                 root_bit
);

  logic [REM_W-1:0] shifted;
  logic [REM_W-1:0] trial;
  logic [REM_W:0]   diff;
  logic             unused_rem_hi;

  // The remainder never exceeds 2*root < 2^26, so the two bits shifted out are always zero.
  assign shifted       = {rem[REM_W-3:0], pair};
  assign trial         = {{(REM_W-ROOT_BITS-2){1'b0}}, root, 2'b01};
  assign diff          = {1'b0, shifted} - {1'b0, trial};
  // No borrow means the trial subtrahend fits: root bit is 1 and the difference is kept.
  assign root_bit      = ~diff[REM_W];
  assign rem_next      = root_bit ? diff[REM_W-1:0] : shifted;
  assign root_next     = {root[ROOT_BITS-2:0], root_bit};
  assign unused_rem_hi = ^rem[REM_W-1:REM_W-2];

endmodule

// File: rtl/fsqrt_iter.sv
// fsqrt_iter: iterative IEEE-754 single-precision square root, one root bit
// per cycle, round-to-nearest-even. One operation in flight.
// Ports:
//   clk       - clock, rising edge
//   rstn      - asynchronous active-low reset
//   in_valid  - operand x presented
//   in_ready  - high only while idle
//   x         - operand, IEEE single
//   out_valid - result available, held until out_ready
//   out_ready - consumer accepts result
//   y         - result, IEEE single
module fsqrt_iter
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y
);

  localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(ROOT_BITS - 1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [RAD_W-1:0]     rad_q;
  logic [REM_W-1:0]     rem_q, rem_next;
  logic [ROOT_BITS-1:0] root_q, root_next;
  logic [EXP_W-1:0]     exp_q;
  logic [31:0]          y_q;
  logic                 unused_root_bit;

  fclass_t              x_class;
  logic                 x_special;
  logic [31:0]          special_y;
  logic [EXP_W-1:0]     x_exp, res_exp;
  logic [MAN_W-1:0]     x_man;
  logic [RAD_W-1:0]     x_rad;
  logic                 accept;

  // Pack the developed root into a result. r is the root without its leading
  // one; r[0] is the round bit. A carry out of the mantissa wraps it to zero
  // and bumps the exponent.
  function automatic logic [31:0] round_pack(input logic [EXP_W-1:0]     e,
                                             input logic [ROOT_BITS-2:0] r,
                                             input logic                 sticky);
    logic           up;
    logic [MAN_W:0] sum;
    up  = r[0] & (sticky | r[1]);
    sum = {1'b0, r[ROOT_BITS-2:1]} + {{MAN_W{1'b0}}, up};
    return {1'b0, e + {{(EXP_W-1){1'b0}}, sum[MAN_W]}, sum[MAN_W-1:0]};
  endfunction

  // Operand decode: special-case result, result exponent and aligned radicand.
  always_comb begin
    x_exp     = x[30:23];
    x_man     = x[22:0];
    x_class   = classify(x[30:0]);
    x_special = 1'b1;
    special_y = NAN_CANON;
    case (x_class)
      FC_ZERO:   special_y = {x[31], 31'b0};
      FC_NAN:    special_y = NAN_CANON;
      FC_INF:    special_y = x[31] ? NAN_CANON : POS_INF;
      default:   x_special = x[31];
    endcase
    // ((E+1)>>1) + 63, written so every exponent bit participates.
    res_exp = {1'b0, x_exp[EXP_W-1:1]} + {{(EXP_W-1){1'b0}}, x_exp[0]} + EXP_W'(BIAS / 2);
    // Odd biased exponent means an even unbiased exponent: no extra factor of 2.
    x_rad   = x_exp[0] ? {2'b01, x_man, 1'b0} : {1'b1, x_man, 2'b00};
  end

  sqrt_step u_step (
    .rem       (rem_q),
    .root      (root_q),
    .pair      (rad_q[RAD_W-1:RAD_W-2]),
    .rem_next  (rem_next),
    .root_next (root_next),
    .root_bit  (unused_root_bit)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid) state_d = x_special ? DONE : ITER;
      end
      ITER: begin
        if (cnt_q == ITER_LAST) state_d = ROUND;
      end
      ROUND: begin
        state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Recurrence datapath: loaded on accept, one step per ITER cycle.
  always_ff @(posedge clk) begin
    case (state_q)
      IDLE: begin
        if (accept) begin
          rem_q  <= '0;
          root_q <= '0;
          rad_q  <= x_rad;
          exp_q  <= res_exp;
          cnt_q  <= '0;
        end
      end
      ITER: begin
        rem_q  <= rem_next;
        root_q <= root_next;
        rad_q  <= {rad_q[RAD_W-3:0], 2'b00};
        cnt_q  <= cnt_q + CNT_W'(1);
      end
      default: ;
    endcase
  end

  // Result register: specials resolve on the accept edge, normals in ROUND.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      y_q <= '0;
    end else if (accept && x_special) begin
      y_q <= special_y;
    end else if (state_q == ROUND) begin
      y_q <= round_pack(exp_q, root_q[ROOT_BITS-2:0], rem_q != '0);
    end
  end

  assign y = y_q;

endmodule

// File: tb/tb_fsqrt_iter.sv
// Self-checking bench for fsqrt_iter: directed values, specials, back-pressure,
// mid-operation reset and a mantissa sweep against a double-precision model.
module tb_fsqrt_iter;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] x = 32'd0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] y;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_q[$];

  fsqrt_iter dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y)
  );

  always #5 clk = ~clk;

  // Normal single -> real.
  function automatic real f2r(input logic [31:0] f);
    logic [10:0] de;
    de = {3'd0, f[30:23]} + 11'd896;
    return $bitstoreal({f[31], de, f[22:0], 29'd0});
  endfunction

  // Reference: specials by rule, normals via double sqrt rounded RNE to single.
  function automatic logic [31:0] ref_sqrt(input logic [31:0] f);
    logic [7:0]  e;
    logic [22:0] m;
    logic [63:0] b;
    logic [10:0] de;
    logic [23:0] sum;
    logic        up;
    e = f[30:23];
    m = f[22:0];
    if (e == 8'h00) return {f[31], 31'd0};
    if (e == 8'hff && m != 23'd0) return 32'h7fc00000;
    if (f[31]) return 32'h7fc00000;
    if (e == 8'hff) return 32'h7f800000;
    b   = $realtobits($sqrt(f2r(f)));
    up  = b[28] & ((|b[27:0]) | b[29]);
    sum = {1'b0, b[51:29]} + {23'd0, up};
    de  = b[62:52] - 11'd896 + {10'd0, sum[23]};
    return {1'b0, de[7:0], sum[22:0]};
  endfunction

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic send(input logic [31:0] xv, input logic [31:0] yexp);
    @(negedge clk);
    x        = xv;
    in_valid = 1'b1;
    exp_q.push_back(yexp);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic take();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  // Called #1 after the accept edge; latency counts that edge as 1.
  task automatic wait_result(input string tag, input int lat_exp, input bit ack);
    int          lat;
    logic [31:0] e;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check32({tag, "_lat"}, 32'(lat), 32'(lat_exp));
    tests++;
    assert (exp_q.size() != 0) else begin
      fails++;
      $error("FAIL %s_sb: observed empty scoreboard expected one entry", tag);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check32(tag, y, e);
    end
    if (ack) take();
  endtask

  initial begin
    logic [31:0] xv;
    real         xr, yr, lo, hi, h;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check32("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check32("rst_y", y, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check32("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Directed normals
    send(32'h3f800000, 32'h3f800000); wait_result("sqrt_1p0", 27, 1'b1);
    send(32'h40800000, 32'h40000000); wait_result("sqrt_4p0", 27, 1'b1);
    send(32'h40000000, 32'h3fb504f3); wait_result("sqrt_2p0", 27, 1'b1);
    send(32'h40100000, 32'h3fc00000); wait_result("sqrt_2p25", 27, 1'b1);

    // Specials, latency 1
    send(32'hbf800000, 32'h7fc00000); wait_result("sp_neg", 1, 1'b1);
    send(32'h80000000, 32'h80000000); wait_result("sp_negzero", 1, 1'b1);
    send(32'h00000001, 32'h00000000); wait_result("sp_denorm", 1, 1'b1);
    send(32'h7f800000, 32'h7f800000); wait_result("sp_posinf", 1, 1'b1);
    send(32'h7fa00000, 32'h7fc00000); wait_result("sp_snan", 1, 1'b1);
    send(32'hff800000, 32'h7fc00000); wait_result("sp_neginf", 1, 1'b1);

    // Back-pressure: result held, new operand ignored until handshake
    send(32'h3f800000, 32'h3f800000);
    wait_result("bp_1p0", 27, 1'b0);
    @(negedge clk);
    x        = 32'h40800000;
    in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      check32($sformatf("bp_hold_y_%0d", k), y, 32'h3f800000);
      check32($sformatf("bp_in_ready_%0d", k), {31'd0, in_ready}, 32'd0);
      check32($sformatf("bp_out_valid_%0d", k), {31'd0, out_valid}, 32'd1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check32("bp_clear_out_valid", {31'd0, out_valid}, 32'd0);
    check32("bp_idle_in_ready", {31'd0, in_ready}, 32'd1);
    exp_q.push_back(32'h40000000);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_result("bp_4p0", 27, 1'b1);

    // Reset mid-operation
    @(negedge clk);
    x        = 32'h40000000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (11) @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check32("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check32("mid_rst_y", y, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check32("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    send(32'h40800000, 32'h40000000); wait_result("post_rst_4p0", 27, 1'b1);

    // Sweep over both exponent parities against the model
    for (int ei = 127; ei <= 128; ei++) begin
      for (int i = 0; i < 16; i++) begin
        xv = {1'b0, 8'(ei), 5'(i), 18'd0};
        send(xv, ref_sqrt(xv));
        wait_result($sformatf("sweep_%0d_%0d", ei, i), 27, 1'b0);
        // Correct rounding: x lies between the squares of y -/+ half an ulp.
        xr = f2r(xv);
        yr = f2r(y);
        h  = $bitstoreal({1'b0, 11'(y[30:23]) + 11'd872, 52'd0});
        lo = (yr - h) * (yr - h);
        hi = (yr + h) * (yr + h);
        tests++;
        assert (lo <= xr && xr <= hi) else begin
          fails++;
          $error("FAIL sq_bracket_%0d_%0d: observed y=%h expected square bracket around %h", ei, i, y, xv);
        end
        take();
      end
    end

    check32("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
